// File: rtl/nibble_add_sequencer_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding, default slice width, idx sizing.
package nibble_add_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 16;
    localparam int unsigned DEFAULT_SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width: clog2 of the slice count, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nslices);
        return (nslices > 1) ? $clog2(nslices) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational SLICE_W-bit ripple slice: {cout_c, sum_c} = a + b + cin.
module nibble_add_slice
    import nibble_add_sequencer_pkg::*;
#(
    parameter int unsigned SLICE_W = DEFAULT_SLICE_W
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum_c,
    output logic               cout_c
);

    assign {cout_c, sum_c} = {1'b0, a} + {1'b0, b} + (SLICE_W+1)'(cin);

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-cycle adder: one SLICE_W slice per clock, LSB first, valid/ready on both sides.
// Optional subtract mode (in_sub port) is enabled by defining NIBBLE_SEQ_SUB_EN.
module nibble_add_sequencer
    import nibble_add_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned SLICE_W = DEFAULT_SLICE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef NIBBLE_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NSLICES = WIDTH / SLICE_W;
    localparam int unsigned IDX_W   = idx_width(NSLICES);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               carry, carry_n;
    logic [WIDTH-1:0]   a_q, a_n, b_q, b_n, sum_q, sum_n;
    logic               cout_q, cout_n;
`ifdef NIBBLE_SEQ_SUB_EN
    logic               sub_q, sub_n;
`endif

    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_c;

    // Operand slice mux; subtraction feeds the inverted B slice.
    always_comb begin
        slice_a = a_q[idx*SLICE_W +: SLICE_W];
        slice_b = b_q[idx*SLICE_W +: SLICE_W];
`ifdef NIBBLE_SEQ_SUB_EN
        if (sub_q) begin
            slice_b = ~slice_b;
        end
`endif
    end

    nibble_add_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .cin    (carry),
        .sum_c  (slice_s),
        .cout_c (slice_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        carry_n = carry;
        a_n     = a_q;
        b_n     = b_q;
        sum_n   = sum_q;
        cout_n  = cout_q;
`ifdef NIBBLE_SEQ_SUB_EN
        sub_n   = sub_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_n     = in_a;
                    b_n     = in_b;
                    idx_n   = '0;
`ifdef NIBBLE_SEQ_SUB_EN
                    sub_n   = in_sub;
                    carry_n = in_sub ? 1'b1 : in_cin;
`else
                    carry_n = in_cin;
`endif
                    state_n = RUN;
                end
            end
            RUN: begin
                sum_n[idx*SLICE_W +: SLICE_W] = slice_s;
                carry_n = slice_c;
                idx_n   = idx + IDX_W'(1);
                if (idx == IDX_W'(NSLICES - 1)) begin
                    cout_n  = slice_c;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef NIBBLE_SEQ_SUB_EN
            sub_q     <= 1'b0;
`endif
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            carry     <= carry_n;
            a_q       <= a_n;
            b_q       <= b_n;
            sum_q     <= sum_n;
            cout_q    <= cout_n;
`ifdef NIBBLE_SEQ_SUB_EN
            sub_q     <= sub_n;
`endif
            in_ready  <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            out_valid <= (state_n == DONE);
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench: 16-bit/4-bit DUT plus a single-slice (WIDTH=4) instance, checked against an arithmetic model.
module tb_nibble_add_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [15:0] in_a, in_b, out_sum;
`ifdef NIBBLE_SEQ_SUB_EN
    logic        in_sub;
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        n1_in_valid, n1_in_ready, n1_in_cin, n1_out_valid, n1_out_ready, n1_out_cout, n1_busy;
    logic [3:0]  n1_in_a, n1_in_b, n1_out_sum;
`ifdef NIBBLE_SEQ_SUB_EN
    logic        n1_in_sub;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    nibble_add_sequencer #(.WIDTH(16), .SLICE_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef NIBBLE_SEQ_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    nibble_add_sequencer #(.WIDTH(4), .SLICE_W(4)) dut_n1 (
        .clk(clk), .reset(reset),
        .in_valid(n1_in_valid), .in_ready(n1_in_ready),
        .in_a(n1_in_a), .in_b(n1_in_b), .in_cin(n1_in_cin),
`ifdef NIBBLE_SEQ_SUB_EN
        .in_sub(n1_in_sub),
`endif
        .out_valid(n1_out_valid), .out_ready(n1_out_ready),
        .out_sum(n1_out_sum), .out_cout(n1_out_cout), .busy(n1_busy)
    );

    // Reference: full-precision arithmetic; bit 16 is the carry (or no-borrow flag).
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b} + 17'(cin);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_sub(input logic sub);
`ifdef NIBBLE_SEQ_SUB_EN
        in_sub = sub;
`endif
    endtask

    // Present operands once the block is ready; returns with the accept edge just passed.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        ok = in_ready;
        in_a = a; in_b = b; in_cin = cin; set_sub(sub);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges from the current point until out_valid; -1 if it never rises.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            tick();
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_sum !== 16'h0 || out_cout !== 1'b0)
            $display("FAIL reset_result got %h/%b want 0000/0", out_sum, out_cout); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (n1_in_ready !== 1'b1 || n1_out_valid !== 1'b0)
            $display("FAIL reset_n1 got ready=%b valid=%b want 1/0", n1_in_ready, n1_out_valid); else passed++;
    endtask

    task automatic test_carry_wrap;
        bit ok; int e;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, ok);
        checks++; if (!ok) $display("FAIL wrap_accept got not-ready want ready"); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL wrap_busy got %b want 1", busy); else passed++;
        wait_valid(e);
        checks++; if (e !== 4) $display("FAIL wrap_latency got %0d want 4", e); else passed++;
        checks++; if (out_sum !== 16'h0000 || out_cout !== 1'b1)
            $display("FAIL wrap_result got %h/%b want 0000/1", out_sum, out_cout); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL wrap_release got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_ready_low;
        bit ok; bit seen_ready = 1'b0; int n = 0;
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, ok);
        while (!out_valid && n < 50) begin
            if (in_ready) seen_ready = 1'b1;
            tick(); n++;
        end
        if (in_ready) seen_ready = 1'b1;
        checks++; if (n !== 4) $display("FAIL rl_latency got %0d want 4", n); else passed++;
        checks++; if (seen_ready !== 1'b0) $display("FAIL rl_in_ready got high want low in RUN/DONE"); else passed++;
        checks++; if (out_sum !== 16'h5556 || out_cout !== 1'b0)
            $display("FAIL rl_result got %h/%b want 5556/0", out_sum, out_cout); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_done_hold;
        bit ok; int e; logic [16:0] exp;
        logic [15:0] a = 16'($urandom); logic [15:0] b = 16'($urandom);
        exp = model(a, b, 1'b0, 1'b0);
        issue(a, b, 1'b0, 1'b0, ok);
        wait_valid(e);
        in_a = ~a; in_b = ~b; in_cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== exp)
                $display("FAIL hold_%0d got v=%b r=%b %b/%h want 1/0 %b/%h",
                         i, out_valid, in_ready, out_cout, out_sum, exp[16], exp[15:0]);
            else passed++;
        end
        in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL hold_no_accept got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_run;
        bit ok; bit seen = 1'b0;
        issue(16'hABCD, 16'h1357, 1'b1, 1'b0, ok);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0 || busy !== 1'b0)
            $display("FAIL abort got r=%b v=%b sum=%h busy=%b want 1/0/0000/0",
                     in_ready, out_valid, out_sum, busy); else passed++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL abort_pulse got out_valid high want none"); else passed++;
    endtask

`ifdef NIBBLE_SEQ_SUB_EN
    task automatic test_sub;
        bit ok; int e;
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, ok);
        wait_valid(e);
        checks++; if (e !== 4 || out_sum !== 16'hFFFE || out_cout !== 1'b0)
            $display("FAIL sub_neg got %0d %h/%b want 4 fffe/0", e, out_sum, out_cout); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, ok);
        wait_valid(e);
        checks++; if (out_sum !== 16'h0002 || out_cout !== 1'b1)
            $display("FAIL sub_pos got %h/%b want 0002/1", out_sum, out_cout); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        set_sub(1'b0);
    endtask
`endif

    task automatic test_random;
        bit ok; int e; logic [16:0] exp;
        for (int k = 0; k < 24; k++) begin
            logic [15:0] a = 16'($urandom);
            logic [15:0] b = 16'($urandom);
            logic cin = 1'($urandom_range(0, 1));
            logic sub = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == 0) begin a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; end
            exp = model(a, b, cin, sub);
            issue(a, b, cin, sub, ok);
            wait_valid(e);
            checks++;
            if (!ok || e !== 4 || {out_cout, out_sum} !== exp)
                $display("FAIL rand_%0d a=%h b=%h c=%b s=%b got lat=%0d %b/%h want 4 %b/%h",
                         k, a, b, cin, sub, e, out_cout, out_sum, exp[16], exp[15:0]);
            else passed++;
            for (int d = $urandom_range(0, 3); d > 0; d--) tick();
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        set_sub(1'b0);
    endtask

    task automatic test_back_to_back;
        logic [16:0] q[$];
        int accepts = 0, results = 0, last_acc = -1, cyc = 0;
        logic sub;
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
        sub = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0; set_sub(sub);
        in_valid = 1'b1; out_ready = 1'b1;
        while (results < 5 && cyc < 200) begin
            bit acc = in_ready && in_valid;
            if (out_valid && out_ready) begin
                logic [16:0] exp = (q.size() > 0) ? q.pop_front() : 17'h0;
                checks++;
                if ({out_cout, out_sum} !== exp)
                    $display("FAIL b2b_result_%0d got %b/%h want %b/%h", results, out_cout, out_sum, exp[16], exp[15:0]);
                else passed++;
                results++;
            end
            if (acc) begin
                q.push_back(model(in_a, in_b, in_cin, sub));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 6) $display("FAIL b2b_interval got %0d want 6", cyc - last_acc);
                    else passed++;
                end
                last_acc = cyc;
                accepts++;
            end
            tick(); cyc++;
            if (acc) begin
                in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
                sub = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0; set_sub(sub);
                if (accepts == 5) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; set_sub(1'b0);
        checks++; if (results !== 5) $display("FAIL b2b_count got %0d want 5", results); else passed++;
    endtask

    task automatic test_single_slice;
        n1_in_a = 4'hF; n1_in_b = 4'hF; n1_in_cin = 1'b1; n1_in_valid = 1'b1;
        tick();
        n1_in_valid = 1'b0;
        checks++; if (n1_out_valid !== 1'b0 || n1_busy !== 1'b1)
            $display("FAIL n1_run got v=%b busy=%b want 0/1", n1_out_valid, n1_busy); else passed++;
        tick();
        checks++; if (n1_out_valid !== 1'b1 || n1_out_sum !== 4'hF || n1_out_cout !== 1'b1)
            $display("FAIL n1_result got v=%b %h/%b want 1 f/1", n1_out_valid, n1_out_sum, n1_out_cout); else passed++;
        n1_out_ready = 1'b1; tick(); n1_out_ready = 1'b0;
        checks++; if (n1_in_ready !== 1'b1 || n1_out_valid !== 1'b0)
            $display("FAIL n1_release got r=%b v=%b want 1/0", n1_in_ready, n1_out_valid); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0; set_sub(1'b0);
        n1_in_valid = 1'b0; n1_in_a = '0; n1_in_b = '0; n1_in_cin = 1'b0; n1_out_ready = 1'b0;
`ifdef NIBBLE_SEQ_SUB_EN
        n1_in_sub = 1'b0;
`endif
        test_reset();
        test_carry_wrap();
        test_ready_low();
        test_done_hold();
        test_reset_mid_run();
`ifdef NIBBLE_SEQ_SUB_EN
        test_sub();
`endif
        test_random();
        test_back_to_back();
        test_single_slice();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
